// File: rtl/seq_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
package seq_adder_pkg;

  typedef enum logic {
    StIdle,
    StBusy
  } state_e;

  // Number of digit cycles per operation.
  function automatic int unsigned digits(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_adder_digit_adder.sv
// Combinational DIGIT-bit ripple slice; also exposes the carry into its top bit.
module digit_adder #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             ctop
);

  always_comb begin
    logic carry;
    carry = cin;
    sum   = '0;
    ctop  = cin;
    for (int i = 0; i < int'(DIGIT); i++) begin
      if (i == int'(DIGIT) - 1) ctop = carry;
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/seq_adder.sv
// Digit-serial adder, LSB digit first, with start/ready/done handshake.
// Define SEQ_ADDER_SUB_EN to add the op port and subtraction.
module seq_adder
  import seq_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CarryIN,
`ifdef SEQ_ADDER_SUB_EN
  input  logic             op,
`endif
  output logic [WIDTH-1:0] Y,
  output logic             CarryOUT,
  output logic             overflow,
  output logic             done
);

  localparam int unsigned N    = digits(WIDTH, DIGIT);
  localparam int unsigned CntW = cnt_width(N);

  if (DIGIT < 1 || WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $fatal(1, "seq_adder: WIDTH must be >= 2 and a multiple of DIGIT >= 1");
  end

  state_e            state;
  logic [CntW-1:0]   cnt;
  logic              carry;
  logic              op_q;
  logic [WIDTH-1:0]  a_q, b_q, res_q;

  logic [DIGIT-1:0]  b_dig, sum_dig;
  logic              d_cout, d_ctop;
  logic [WIDTH-1:0]  res_next;

  // Subtract feeds the inverted B digit; the seed carry supplies the +1.
  assign b_dig = b_q[DIGIT-1:0] ^ {DIGIT{op_q}};

  digit_adder #(
    .DIGIT(DIGIT)
  ) u_digit_adder (
    .a   (a_q[DIGIT-1:0]),
    .b   (b_dig),
    .cin (carry),
    .sum (sum_dig),
    .cout(d_cout),
    .ctop(d_ctop)
  );

  // New digit enters at the top so the first digit lands at bit 0 after N shifts.
  always_comb begin
    res_next = (res_q >> DIGIT) | (WIDTH'(sum_dig) << (WIDTH - DIGIT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StIdle;
      ready    <= 1'b1;
      done     <= 1'b0;
      Y        <= '0;
      CarryOUT <= 1'b0;
      overflow <= 1'b0;
      cnt      <= '0;
      carry    <= 1'b0;
      op_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            a_q   <= A;
            b_q   <= B;
            cnt   <= '0;
            state <= StBusy;
            ready <= 1'b0;
`ifdef SEQ_ADDER_SUB_EN
            op_q  <= op;
            carry <= op ? 1'b1 : CarryIN;
`else
            op_q  <= 1'b0;
            carry <= CarryIN;
`endif
          end
        end
        StBusy: begin
          a_q   <= a_q >> DIGIT;
          b_q   <= b_q >> DIGIT;
          res_q <= res_next;
          carry <= d_cout;
          cnt   <= cnt + 1'b1;
          if (cnt == CntW'(N - 1)) begin
            state    <= StIdle;
            ready    <= 1'b1;
            done     <= 1'b1;
            Y        <= res_next;
            CarryOUT <= d_cout;
            overflow <= d_cout ^ d_ctop;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_adder.sv
// Directed self-checking bench for seq_adder (8/2 and 4/4 configurations).
module tb_seq_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start, ready, ci, co, ovf, done, op;
  logic [7:0] a, b, y;

  logic       start4, ready4, ci4, co4, ovf4, done4;
  logic [3:0] a4, b4, y4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_adder #(
    .WIDTH(8),
    .DIGIT(2)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .ready   (ready),
    .A       (a),
    .B       (b),
    .CarryIN (ci),
`ifdef SEQ_ADDER_SUB_EN
    .op      (op),
`endif
    .Y       (y),
    .CarryOUT(co),
    .overflow(ovf),
    .done    (done)
  );

  seq_adder #(
    .WIDTH(4),
    .DIGIT(4)
  ) u_dut4 (
    .clk     (clk),
    .rst     (rst),
    .start   (start4),
    .ready   (ready4),
    .A       (a4),
    .B       (b4),
    .CarryIN (ci4),
`ifdef SEQ_ADDER_SUB_EN
    .op      (1'b0),
`endif
    .Y       (y4),
    .CarryOUT(co4),
    .overflow(ovf4),
    .done    (done4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 8-bit operation with full latency, handshake and hold checks.
  task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                        input logic ici, input logic iop, input logic [7:0] ey,
                        input logic eco, input logic eovf);
    a = ia; b = ib; ci = ici; op = iop; start = 1'b1;
    tick();
    start = 1'b0; a = 8'h00; b = 8'h00; ci = 1'b0;
    check({tag, ".ready0"}, ready, 0);
    for (int i = 1; i < 4; i++) begin
      tick();
      check({tag, ".busy_ready"}, ready, 0);
      check({tag, ".busy_done"}, done, 0);
    end
    tick();
    check({tag, ".done"}, done, 1);
    check({tag, ".ready1"}, ready, 1);
    check({tag, ".Y"}, y, ey);
    check({tag, ".co"}, co, eco);
    check({tag, ".ovf"}, ovf, eovf);
    tick();
    check({tag, ".done_pulse"}, done, 0);
    check({tag, ".Y_hold"}, y, ey);
  endtask

  initial begin
    start = 0; a = 0; b = 0; ci = 0; op = 0;
    start4 = 0; a4 = 0; b4 = 0; ci4 = 0;
    #12;
    check("rst.ready", ready, 1);
    check("rst.done", done, 0);
    check("rst.Y", y, 0);
    check("rst.co", co, 0);
    check("rst.ovf", ovf, 0);
    rst = 1'b0;
    tick();

    run_op("add7f", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("addff", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
    run_op("add55", 8'h55, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
`ifdef SEQ_ADDER_SUB_EN
    run_op("sub80", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);
`endif

    // Back-to-back with a stray start mid-BUSY.
    a = 8'h10; b = 8'h20; ci = 0; op = 0; start = 1;
    tick();
    start = 0; a = 0; b = 0;
    tick();
    a = 8'hFF; b = 8'hFF; ci = 1; start = 1;
    tick();
    start = 0; a = 0; b = 0; ci = 0;
    tick();
    tick();
    check("b2b.done1", done, 1);
    check("b2b.Y1", y, 8'h30);
    a = 8'h06; b = 8'h02; start = 1;
    tick();
    start = 0; a = 0; b = 0;
    check("b2b.accept", ready, 0);
    check("b2b.Y_hold", y, 8'h30);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("b2b.busy_done", done, 0);
    end
    tick();
    check("b2b.done2", done, 1);
    check("b2b.Y2", y, 8'h08);
    tick();

    // Reset mid-operation, then a fresh operation.
    a = 8'hFF; b = 8'hFF; start = 1;
    tick();
    start = 0; a = 0; b = 0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midrst.ready", ready, 1);
    check("midrst.done", done, 0);
    check("midrst.Y", y, 0);
    check("midrst.co", co, 0);
    check("midrst.ovf", ovf, 0);
    #1;
    rst = 1'b0;
    tick();
    check("midrst.idle", ready, 1);
    run_op("fresh", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);

    // Single-cycle configuration.
    a4 = 4'b0110; b4 = 4'b0010; ci4 = 0; start4 = 1;
    tick();
    start4 = 0; a4 = 0; b4 = 0;
    check("w4.ready0", ready4, 0);
    check("w4.done0", done4, 0);
    tick();
    check("w4.done", done4, 1);
    check("w4.Y", y4, 4'b1000);
    check("w4.co", co4, 0);
    check("w4.ovf", ovf4, 1);
    a4 = 4'hF; b4 = 4'hF; ci4 = 1; start4 = 1;
    tick();
    start4 = 0; a4 = 0; b4 = 0; ci4 = 0;
    tick();
    check("w4b.done", done4, 1);
    check("w4b.Y", y4, 4'hF);
    check("w4b.co", co4, 1);
    check("w4b.ovf", ovf4, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
